// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns toggle-flagged writes to the io_lcd word into HD44780 8-bit write cycles.
// Latency: RS/DATA drive the edge after acceptance; EN rises SETUP_CYC later for EN_CYC clocks;
//          busy_o clears SETUP+EN+HOLD+wait clocks after acceptance (wait = CLR_CYC for clear/home).
// Backpressure: none on the source; toggles seen while busy stay pending, an even count cancels out.
//
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   io_lcd[31]         display power, mirrored to lcd_on_o one clock later
//   io_lcd[30]         request toggle (differs from last accepted value => request pending)
//   io_lcd[8], [7:0]   RS and data byte, sampled at acceptance
//   lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o   LCD pins (rw tied low)
//   busy_o             high whenever the FSM is not in IDLE
//
// Optional build macro LCD_INIT_EN: after reset wait PWRUP_CYC clocks, then issue the
// controller init sequence 0x38,0x38,0x38,0x0C,0x01,0x06 before accepting software writes.

module lcd_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2000,
    parameter int CLR_CYC   = 82000,
    parameter int PWRUP_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] io_lcd,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        busy_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_P = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                max2(CLR_CYC, PWRUP_CYC));
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // INIT names the init-command dispatch; it never holds a clock because PWRUP
    // and EXEC load the next init command straight into SETUP.
    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        INIT  = 3'd1,
        IDLE  = 3'd2,
        SETUP = 3'd3,
        PULSE = 3'd4,
        HOLD  = 3'd5,
        EXEC  = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tog_q;
    logic             long_wait;
    logic             unused_bits;

`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
    localparam logic [2:0]       INIT_LEN = 3'd6;

    logic [2:0] init_idx;   // index of the next init command to issue

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = 8'h38;  // function set: 8-bit, 2 lines, 5x8
            3'd3:             cmd = 8'h0C;  // display on, cursor off
            3'd4:             cmd = 8'h01;  // clear
            3'd5:             cmd = 8'h06;  // entry mode: increment, no shift
            default:          cmd = 8'h00;
        endcase
        return cmd;
    endfunction
`endif

    assign lcd_rw_o    = 1'b0;
    assign unused_bits = ^io_lcd[29:9];

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign long_wait = !lcd_rs_o && (lcd_data_o[7:2] == 6'd0) && (lcd_data_o != 8'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lcd_data_o <= 8'h00;
            lcd_rs_o   <= 1'b0;
            lcd_en_o   <= 1'b0;
            lcd_on_o   <= 1'b0;
            tog_q      <= 1'b0;
`ifdef LCD_INIT_EN
            state      <= PWRUP;
            cnt        <= PWRUP_LD;
            busy_o     <= 1'b1;
            init_idx   <= 3'd0;
`else
            state      <= IDLE;
            cnt        <= '0;
            busy_o     <= 1'b0;
`endif
        end else begin
            lcd_on_o <= io_lcd[31];

            case (state)
`ifdef LCD_INIT_EN
                PWRUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        lcd_rs_o   <= 1'b0;
                        lcd_data_o <= init_cmd(3'd0);
                        init_idx   <= 3'd1;
                        cnt        <= SETUP_LD;
                        state      <= SETUP;
                    end
                end
`endif
                IDLE: begin
                    if (io_lcd[30] != tog_q) begin
                        tog_q      <= io_lcd[30];
                        lcd_rs_o   <= io_lcd[8];
                        lcd_data_o <= io_lcd[7:0];
                        cnt        <= SETUP_LD;
                        busy_o     <= 1'b1;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        lcd_en_o <= 1'b1;
                        cnt      <= EN_LD;
                        state    <= PULSE;
                    end
                end

                PULSE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        lcd_en_o <= 1'b0;
                        cnt      <= HOLD_LD;
                        state    <= HOLD;
                    end
                end

                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        cnt   <= long_wait ? CLR_LD : EXEC_LD;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
`ifdef LCD_INIT_EN
                    else if (init_idx != INIT_LEN) begin
                        lcd_rs_o   <= 1'b0;
                        lcd_data_o <= init_cmd(init_idx);
                        init_idx   <= init_idx + 3'd1;
                        cnt        <= SETUP_LD;
                        state      <= SETUP;
                    end
`endif
                    else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    lcd_en_o <= 1'b0;
                    busy_o   <= 1'b0;
                    cnt      <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
